bit_serial_adder: RTL
=====================

# bit_serial_adder

- Multi-cycle WIDTH-bit adder that processes operands LSB-first, one bit per clock, through a single 1-bit full-adder cell and a registered carry.
- Sits alongside the combinational adder library as the area-minimal alternative: one full-adder cell plus shift registers instead of a WIDTH-bit ripple chain.
- Consumes parallel operands via a start/busy/done handshake and presents a parallel result.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to add a, b, cin; sampled only when idle (IDLE or DONE state).
- a  input  WIDTH  operand A; captured on the accepting edge only.
- b  input  WIDTH  operand B; captured on the accepting edge only.
- cin  input  1  carry-in; captured on the accepting edge only.
- busy  output  1  high while bits are being processed (RUN state).
- done  output  1  one-cycle pulse; sum/cout valid from this cycle.
- sum  output  WIDTH  registered result; held until the next completion.
- cout  output  1  registered carry-out; held until the next completion.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - Load a into ra and b into rb.
  - Load cin into the carry register.
  - Clear the bit counter and the sum shift register sr.
  - Transition to RUN.
- IDLE, start=0: remain in IDLE.
- RUN, each cycle:
  - The full-adder cell computes s/c from ra[0], rb[0] and carry.
  - ra and rb shift right by 1.
  - sr shifts right with s entering sr[WIDTH-1].
  - carry takes c; the counter increments.
- RUN, last bit: when counter == WIDTH-1, latch sum <= {s, sr[WIDTH-1:1]} and cout <= c, then transition to DONE.
- DONE: done=1 for exactly one cycle.
  - start=1: accept new operands exactly as in IDLE and go to RUN (back-to-back operation).
  - start=0: go to IDLE.
- start during RUN is ignored; no queuing, and the captured operands are unaffected.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1), unsigned. Signed operands give correct two's-complement sum bits; overflow detection is out of scope.
- Counter width is $clog2(WIDTH). The counter never wraps within an operation.
- rst=1, at any time including mid-RUN:
  - State goes to IDLE; the operation is aborted and no done is produced.
  - busy, done, sum and cout go to 0.
  - ra, rb, sr, carry and counter are cleared.
- Reset values: busy=0, done=0, sum=0, cout=0.

## Timing
- start accepted at the rising edge closing cycle t.
- busy=1 in cycles t+1 .. t+WIDTH.
- done=1 in cycle t+WIDTH+1; sum/cout take their new value in that same cycle.
- Latency from accepting edge to done is WIDTH+1 cycles.
- Throughput: one addition per WIDTH+1 cycles when start is held high.
- sum and cout never show partial results; they change only on the RUN→DONE edge or on reset.
- busy and done are never high together.
- No combinational path from any input to any output.

## Structure
- Package bit_serial_adder_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} state_t.
  - The default WIDTH constant.
- Sub-module fa_cell: combinational 1-bit full adder (a, b, cin → sum, cout), built from two-input NAND primitives, instantiated once.
- Top level contains:
  - the FSM;
  - the operand shift registers;
  - the sum shift register;
  - the carry flop;
  - the counter;
  - the result registers.

## Test plan
- WIDTH=8; a=0x0F, b=0x01, cin=0, start for one cycle at t → busy in t+1..t+8; done in t+9 only; sum=0x10, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Start held high continuously with new operands (0x12+0x34, then 0xA5+0x5A cin=1):
  - done pulses at t+9 and t+18;
  - results 0x46/cout0, then 0x00/cout1.
- start pulsed at t+3 with different a/b during RUN → ignored; result at t+9 matches the operands captured at t.
- rst asserted in cycle t+4 of a RUN:
  - busy=0, done=0, sum=0, cout=0 next cycle;
  - no done pulse follows;
  - a fresh start then completes correctly.
- Random sweep, 1000 vectors, WIDTH=8 and WIDTH=13 → {cout,sum} equals a+b+cin; done always exactly WIDTH+1 cycles after acceptance.

Source files
------------

// File: rtl/bit_serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Holds the FSM state encoding and the default operand width.
package bit_serial_adder_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/bit_serial_adder_if.sv
// Start/busy/done handshake and parallel operand/result bus of the bit-serial adder.
// The master drives the request and the slave (the adder) returns status and result.
interface bit_serial_adder_if
   import bit_serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
   );

endinterface

// File: rtl/bit_serial_adder_fa_cell.sv
// Combinational 1-bit full adder built only from two-input NAND gates.
// Nine-gate form: n1 is shared between the XOR tree and the carry.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic n1;
   logic n2;
   logic n3;
   logic x1;
   logic n4;
   logic n5;
   logic n6;

   // First half adder: x1 = a ^ b, n1 = ~(a & b)
   nand g1 (n1, a, b);
   nand g2 (n2, a, n1);
   nand g3 (n3, b, n1);
   nand g4 (x1, n2, n3);

   // Second half adder: sum = x1 ^ cin, n4 = ~(x1 & cin)
   nand g5 (n4, x1, cin);
   nand g6 (n5, x1, n4);
   nand g7 (n6, cin, n4);
   nand g8 (sum, n5, n6);

   // cout = (a & b) | (x1 & cin)
   nand g9 (cout, n1, n4);

endmodule

// File: rtl/bit_serial_adder.sv
// Multi-cycle adder: one full-adder cell walks the operands LSB-first, one bit per clock.
// Result and carry-out are registered and only change on completion or reset.
module bit_serial_adder
   import bit_serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   bit_serial_adder_if.slave  bus
);

   localparam int unsigned       CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] ra;
   logic [WIDTH-1:0] rb;
   logic [WIDTH-1:0] sr;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;

   logic             s;
   logic             c;

   fa_cell u_fa (
      .a    (ra[0]),
      .b    (rb[0]),
      .cin  (carry),
      .sum  (s),
      .cout (c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         ra     <= '0;
         rb     <= '0;
         sr     <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  ra     <= bus.a;
                  rb     <= bus.b;
                  carry  <= bus.cin;
                  sr     <= '0;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= RUN;
               end else begin
                  state  <= IDLE;
               end
            end
            RUN: begin
               ra    <= ra >> 1;
               rb    <= rb >> 1;
               sr    <= {s, sr[WIDTH-1:1]};
               carry <= c;
               // Counter holds on the final bit so it never wraps inside an operation.
               if (cnt == LAST) begin
                  sum_q  <= {s, sr[WIDTH-1:1]};
                  cout_q <= c;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= DONE;
               end else begin
                  cnt    <= cnt + 1'b1;
               end
            end
            default: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;

endmodule
